// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, decode handshake and redirect.
// master = fetch unit, slave = memory/decode environment.
`default_nettype none

interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  modport master (
    output imem_addr,
    input  imem_rd,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_misaligned
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    output redirect_valid,
    output redirect_pc,
    input  fetch_misaligned
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC owner, async-read imem initiator, {pc,instr} FIFO to decode.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect sets a sticky flag and halts fetch.
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instr_fetch_unit_if.master    bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      fifo_mem [FIFO_DEPTH];

  logic [31:0] pc_q,         pc_d;
  ptr_t        wr_ptr_q,     wr_ptr_d;
  ptr_t        rd_ptr_q,     rd_ptr_d;
  cnt_t        count_q,      count_d;
  logic        misaligned_q, misaligned_d;

  logic        head_valid;
  logic        deq;
  logic        enq;
  logic        wr_en;
  entry_t      head;

`ifndef FETCH_ALIGN_CHECK_EN
  // Low address bits are dropped on redirect when the alignment check is compiled out.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    head_valid   = (count_q != '0);
    deq          = head_valid & bus.if_ready;
    // A full buffer still accepts a new word when the head leaves this same cycle.
    enq          = ((count_q < cnt_t'(FIFO_DEPTH)) | deq) & ~misaligned_q;

    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    misaligned_d = misaligned_q;
    wr_en        = 1'b0;

    if (bus.redirect_valid) begin
      // A head consumed alongside the redirect is already gone; the rest is dropped.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end else begin
        pc_d = bus.redirect_pc;
      end
`else
      pc_d = {bus.redirect_pc[31:2], 2'b00};
`endif
    end else begin
      if (enq) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
        pc_d     = pc_q + 32'd4;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(enq) - cnt_t'(deq);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q decides validity and outputs are gated by it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q] <= '{pc: pc_q, instr: bus.imem_rd};
    end
  end

  assign head                 = fifo_mem[rd_ptr_q];
  assign bus.imem_addr        = pc_q;
  assign bus.if_valid         = head_valid;
  assign bus.if_pc            = head_valid ? head.pc    : 32'h0;
  assign bus.if_instr         = head_valid ? head.instr : 32'h0;
  assign bus.fetch_misaligned = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected {pc,instr}, monitors pop on handshake.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_a_n;
  logic        rst_b_n;
  logic [31:0] mask;

  always #5 clk = ~clk;

  instr_fetch_unit_if ifc_a ();
  instr_fetch_unit_if ifc_b ();

  // Instruction memory model: word = address XOR a per-test mask.
  assign ifc_a.imem_rd = ifc_a.imem_addr ^ mask;
  assign ifc_b.imem_rd = ifc_b.imem_addr ^ mask;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .bus     (ifc_a.master)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .bus     (ifc_b.master)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_a(input logic [31:0] pc);
    q_a.push_back('{pc: pc, instr: pc ^ mask});
  endtask

  task automatic expect_b(input logic [31:0] pc);
    q_b.push_back('{pc: pc, instr: pc ^ mask});
  endtask

  task automatic do_reset_a(input int n);
    rst_a_n              = 1'b0;
    ifc_a.if_ready       = 1'b0;
    ifc_a.redirect_valid = 1'b0;
    ifc_a.redirect_pc    = 32'h0;
    cyc(n);
    rst_a_n              = 1'b1;
  endtask

  // Monitors: compare every accepted head against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_a_n === 1'b1 && ifc_a.if_valid === 1'b1 && ifc_a.if_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected: got pc=%h instr=%h, expected no handshake",
                 ifc_a.if_pc, ifc_a.if_instr);
      end else begin
        e = q_a.pop_front();
        check("a_pc",    ifc_a.if_pc,    e.pc);
        check("a_instr", ifc_a.if_instr, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_b_n === 1'b1 && ifc_b.if_valid === 1'b1 && ifc_b.if_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected: got pc=%h instr=%h, expected no handshake",
                 ifc_b.if_pc, ifc_b.if_instr);
      end else begin
        e = q_b.pop_front();
        check("b_pc",    ifc_b.if_pc,    e.pc);
        check("b_instr", ifc_b.if_instr, e.instr);
      end
    end
  end

  initial begin
    rst_a_n              = 1'b0;
    rst_b_n              = 1'b0;
    mask                 = 32'h0;
    ifc_a.if_ready       = 1'b0;
    ifc_a.redirect_valid = 1'b0;
    ifc_a.redirect_pc    = 32'h0;
    ifc_b.if_ready       = 1'b0;
    ifc_b.redirect_valid = 1'b0;
    ifc_b.redirect_pc    = 32'h0;

    // 1: reset state, then stream 0,4,8,C with word = address
    cyc(1);
    check("rst_imem_addr",  ifc_a.imem_addr,        32'h0);
    check("rst_if_valid",   32'(ifc_a.if_valid),    32'h0);
    check("rst_if_instr",   ifc_a.if_instr,         32'h0);
    check("rst_if_pc",      ifc_a.if_pc,            32'h0);
    check("rst_misaligned", 32'(ifc_a.fetch_misaligned), 32'h0);
    cyc(1);
    check("rst_imem_addr2", ifc_a.imem_addr,        32'h0);
    rst_a_n        = 1'b1;
    ifc_a.if_ready = 1'b1;
    expect_a(32'h0); expect_a(32'h4); expect_a(32'h8); expect_a(32'hC);
    cyc(5);
    ifc_a.if_ready = 1'b0;
    check("t1_drain", 32'(q_a.size()), 32'h0);

    // 2: backpressure fills the buffer and freezes the fetch address
    mask = 32'h5A5A_0000;
    do_reset_a(1);
    cyc(1);
    check("t2_valid_first", 32'(ifc_a.if_valid), 32'h1);
    check("t2_addr_first",  ifc_a.imem_addr,     32'h4);
    cyc(4);
    check("t2_hold_valid",  32'(ifc_a.if_valid), 32'h1);
    check("t2_hold_pc",     ifc_a.if_pc,         32'h0);
    check("t2_hold_instr",  ifc_a.if_instr,      32'h0 ^ mask);
    check("t2_hold_addr",   ifc_a.imem_addr,     32'h8);
    expect_a(32'h0); expect_a(32'h4); expect_a(32'h8);
    ifc_a.if_ready = 1'b1;
    cyc(3);
    ifc_a.if_ready = 1'b0;
    check("t2_drain", 32'(q_a.size()), 32'h0);

    // 3: redirect while holding 0,4 with a simultaneous dequeue of 0
    mask = 32'h0123_0000;
    do_reset_a(1);
    cyc(3);
    check("t3_full_pc",   ifc_a.if_pc,     32'h0);
    check("t3_full_addr", ifc_a.imem_addr, 32'h8);
    expect_a(32'h0);
    ifc_a.if_ready       = 1'b1;
    ifc_a.redirect_valid = 1'b1;
    ifc_a.redirect_pc    = 32'h40;
    cyc(1);
    ifc_a.redirect_valid = 1'b0;
    check("t3_flush_valid", 32'(ifc_a.if_valid), 32'h0);
    check("t3_flush_addr",  ifc_a.imem_addr,     32'h40);
    expect_a(32'h40); expect_a(32'h44);
    cyc(3);
    ifc_a.if_ready = 1'b0;
    check("t3_drain", 32'(q_a.size()), 32'h0);

    // 5: reset asserted for one cycle while full
    mask = 32'hBEEF_0000;
    do_reset_a(1);
    cyc(3);
    check("t5_full_valid", 32'(ifc_a.if_valid), 32'h1);
    check("t5_full_addr",  ifc_a.imem_addr,     32'h8);
    rst_a_n = 1'b0;
    cyc(1);
    check("t5_rst_valid", 32'(ifc_a.if_valid), 32'h0);
    check("t5_rst_addr",  ifc_a.imem_addr,     32'h0);
    rst_a_n        = 1'b1;
    ifc_a.if_ready = 1'b1;
    expect_a(32'h0); expect_a(32'h4);
    cyc(3);
    ifc_a.if_ready = 1'b0;
    check("t5_drain", 32'(q_a.size()), 32'h0);

    // 6: misaligned redirect to 0x42
    mask = 32'h7777_0000;
    do_reset_a(1);
    cyc(2);
    ifc_a.redirect_valid = 1'b1;
    ifc_a.redirect_pc    = 32'h42;
    cyc(1);
    ifc_a.redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("t6_misaligned", 32'(ifc_a.fetch_misaligned), 32'h1);
    check("t6_valid",      32'(ifc_a.if_valid),         32'h0);
    ifc_a.if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("t6_valid_stuck", 32'(ifc_a.if_valid),      32'h0);
    end
    check("t6_misaligned_sticky", 32'(ifc_a.fetch_misaligned), 32'h1);
    ifc_a.if_ready = 1'b0;
`else
    check("t6_misaligned", 32'(ifc_a.fetch_misaligned), 32'h0);
    check("t6_valid",      32'(ifc_a.if_valid),         32'h0);
    check("t6_addr",       ifc_a.imem_addr,             32'h40);
    expect_a(32'h40); expect_a(32'h44);
    ifc_a.if_ready = 1'b1;
    cyc(3);
    ifc_a.if_ready = 1'b0;
    check("t6_drain", 32'(q_a.size()), 32'h0);
`endif

    // 7: redirects on consecutive cycles, the last one wins
    mask = 32'h3C3C_0000;
    do_reset_a(1);
    ifc_a.if_ready = 1'b1;
    cyc(1);
    expect_a(32'h0);
    ifc_a.redirect_valid = 1'b1;
    ifc_a.redirect_pc    = 32'h80;
    cyc(1);
    check("t7_first_valid", 32'(ifc_a.if_valid), 32'h0);
    check("t7_first_addr",  ifc_a.imem_addr,     32'h80);
    ifc_a.redirect_pc    = 32'h100;
    cyc(1);
    ifc_a.redirect_valid = 1'b0;
    check("t7_last_valid", 32'(ifc_a.if_valid), 32'h0);
    check("t7_last_addr",  ifc_a.imem_addr,     32'h100);
    expect_a(32'h100); expect_a(32'h104);
    cyc(3);
    ifc_a.if_ready = 1'b0;
    check("t7_drain", 32'(q_a.size()), 32'h0);

    // 4: PC wrap from RESET_PC = FFFF_FFF8 on the second instance
    mask = 32'h0F0F_0000;
    cyc(1);
    check("t4_rst_addr",  ifc_b.imem_addr,     32'hFFFF_FFF8);
    check("t4_rst_valid", 32'(ifc_b.if_valid), 32'h0);
    rst_b_n        = 1'b1;
    ifc_b.if_ready = 1'b1;
    expect_b(32'hFFFF_FFF8); expect_b(32'hFFFF_FFFC); expect_b(32'h0000_0000); expect_b(32'h0000_0004);
    cyc(5);
    ifc_b.if_ready = 1'b0;
    check("t4_drain", 32'(q_b.size()), 32'h0);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
